dma_req_sched: RTL and testbench
================================

Name: dma_req_sched

Overview:
- Round-robin scheduler that shares the single SDRAM<->ping-pong-memory DMA engine between several requesters (input-feature loader, weight loader, result writeback).
- Accepts one transfer descriptor at a time: direction, SDRAM start address and SDRAM end address.
- Launches the DMA controller with a one-cycle enable and waits for its finish pulse.
- Reports per-requester acknowledge and completion, with a watchdog for hung transfers.

Parameters:
- NREQ, 3, number of requesters (2..8).
- AW, 8, SDRAM address width.
- TIMEOUT, 1024, max cycles allowed in WAIT before abort.
- TW, 11, watchdog counter width; must satisfy 2^TW > TIMEOUT.

Ports:
- clk_h  in  1  clock.
- rst_n  in  1  reset.
- req  in  NREQ  per-requester request level.
- req_rw  in  NREQ  per-requester direction: 0 = sdram->memory, 1 = memory->sdram.
- req_beg  in  NREQ*AW  flattened start addresses; requester i uses bits [i*AW +: AW].
- req_dst  in  NREQ*AW  flattened end addresses, same packing.
- ack  out  NREQ  one-hot pulse: descriptor accepted.
- done  out  NREQ  one-hot pulse: transfer finished or aborted.
- done_err  out  1  qualifies the done pulse: 1 = aborted or rejected.
- err_sticky  out  1  latched error flag.
- err_clr  in  1  clears err_sticky.
- dma_enable  out  1  one-cycle launch pulse to the DMA control.
- dma_rw  out  1  latched direction.
- dma_sdram_beg  out  AW  latched start address.
- dma_sdram_dst  out  AW  latched end address.
- dma_finish  in  1  pulse from the DMA control on completion.
- busy  out  1  high in every state other than IDLE.

Behaviour:
- Reset: rst_n is synchronous, active-low, and the clock is clk_h. Reset puts the FSM in IDLE and the round-robin pointer at 0. It clears ack, done, done_err, err_sticky, dma_enable, dma_rw, dma_sdram_beg, dma_sdram_dst and busy to 0, and clears the watchdog.
- Registered outputs: all outputs are registered.

State machine:
- IDLE:
  - If any req bit is high, select winner g: the first set bit searching upward from pointer (wrapping past NREQ-1 to 0).
  - Latch g and its rw/beg/dst.
  - If dst >= beg, go to LAUNCH; otherwise go to REJECT.
  - If no req bit is high, stay in IDLE.
- LAUNCH, one cycle:
  - ack[g]=1 and dma_enable=1; descriptor outputs are valid.
  - Pointer becomes (g+1) mod NREQ.
  - Go to WAIT.
- WAIT:
  - dma_enable=0; watchdog increments each cycle.
  - If dma_finish=1, go to DONE with error flag 0.
  - Else if watchdog == TIMEOUT-1, go to DONE with error flag 1 and set err_sticky.
- REJECT, one cycle:
  - ack[g]=1; err_sticky set; pointer advances as in LAUNCH.
  - dma_enable stays 0.
  - Go to DONE with error flag 1.
- DONE, one cycle:
  - done[g]=1 and done_err = error flag; watchdog cleared.
  - Go to IDLE.

Timing:
- Request sampled in IDLE at cycle N produces ack and dma_enable at N+1.
- dma_finish sampled at cycle M produces done at M+1.
- Minimum request-to-request spacing for the same DMA is 4 cycles.

Handshake rules:
- A requester holds req and keeps its descriptor stable until it sees ack; it may drop req in the cycle after ack.
- req already high during DONE waits for the next IDLE. No back-to-back skip of IDLE.
- dma_finish is ignored in every state except WAIT. A finish arriving in the LAUNCH cycle is lost, because the DMA control needs at least 2 cycles.
- Descriptor outputs hold their value until the next LAUNCH.

Boundary conditions:
- Equal addresses (beg == dst) are legal and mean a single-word transfer.
- Simultaneous requests are served round-robin; no requester is starved. Worst-case wait is NREQ-1 transfers.
- If err_clr and an error-setting event occur in the same cycle, set wins.
- A request with no granted req bit never produces ack or done.
- Reset asserted mid-transfer aborts with no done pulse. The DMA control is reset by the same rst_n.
- Outside done pulses, done_err is 0.

Test Plan:
- Single request: req=3'b001, rw=0, beg=8'h10, dst=8'h1F; finish 20 cycles after enable → ack[0] at cycle N+1, dma_enable exactly one cycle with beg=10 and dst=1F, done[0]=1 with done_err=0 one cycle after finish.
- Round-robin: req=3'b111 held, each grant dropping after its ack → grant order 0,1,2, then 0 again on re-request. ack is never more than one-hot.
- Rejection: requester 2 with beg=8'h40, dst=8'h3F → ack[2] and done[2] with done_err=1, dma_enable never asserted, err_sticky=1.
- Timeout: TIMEOUT=16, no dma_finish → done[g] with done_err=1 exactly 16 WAIT cycles after LAUNCH, err_sticky=1. Then err_clr → err_sticky=0.
- Spurious finish: dma_finish pulsed in IDLE and in LAUNCH → no done pulse; the transfer still waits for a finish in WAIT.
- Reset mid-WAIT: rst_n low for one cycle → every output is 0, the FSM is in IDLE, and the next grant goes to requester 0.

Source files
------------

// File: rtl/dma_req_sched.sv
// Round-robin scheduler that shares one SDRAM<->ping-pong DMA engine between NREQ requesters.
// Launches the DMA with a one-cycle enable, then reports completion, rejection or a watchdog abort.
module dma_req_sched #(
    parameter int NREQ    = 3,
    parameter int AW      = 8,
    parameter int TIMEOUT = 1024,
    parameter int TW      = 11
) (
    input  logic               clk_h,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req_i,
    input  logic [NREQ-1:0]    req_rw_i,
    input  logic [NREQ*AW-1:0] req_beg_i,
    input  logic [NREQ*AW-1:0] req_dst_i,
    output logic [NREQ-1:0]    ack_o,
    output logic [NREQ-1:0]    done_o,
    output logic               done_err_o,
    output logic               err_sticky_o,
    input  logic               err_clr_i,
    output logic               dma_enable_o,
    output logic               dma_rw_o,
    output logic [AW-1:0]      dma_sdram_beg_o,
    output logic [AW-1:0]      dma_sdram_dst_o,
    input  logic               dma_finish_i,
    output logic               busy_o
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_REJECT,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [PW-1:0]     gnt_q, gnt_d;
    logic [TW-1:0]     wdog_q, wdog_d;
    logic [NREQ-1:0]   ack_q, ack_d;
    logic [NREQ-1:0]   done_q, done_d;
    logic              done_err_q, done_err_d;
    logic              err_sticky_q, err_sticky_d;
    logic              dma_enable_q, dma_enable_d;
    logic              dma_rw_q, dma_rw_d;
    logic [AW-1:0]     beg_q, beg_d;
    logic [AW-1:0]     dst_q, dst_d;
    logic              busy_q, busy_d;

    logic              win_found;
    logic [PW-1:0]     win_idx;
    logic [PW-1:0]     cand;
    logic [AW-1:0]     sel_beg;
    logic [AW-1:0]     sel_dst;
    logic [PW-1:0]     ptr_next;

    // First requesting index at or above the pointer, wrapping around.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = PW'((int'(ptr_q) + i) % NREQ);
            if (!win_found && req_i[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign sel_beg  = req_beg_i[win_idx*AW +: AW];
    assign sel_dst  = req_dst_i[win_idx*AW +: AW];
    assign ptr_next = (gnt_q == PW'(NREQ-1)) ? '0 : gnt_q + 1'b1;

    // NOTE: every next-state variable gets its default first, so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        gnt_d        = gnt_q;
        wdog_d       = '0;
        ack_d        = '0;
        done_d       = '0;
        done_err_d   = 1'b0;
        err_sticky_d = err_clr_i ? 1'b0 : err_sticky_q;
        dma_enable_d = 1'b0;
        dma_rw_d     = dma_rw_q;
        beg_d        = beg_q;
        dst_d        = dst_q;

        unique case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    gnt_d = win_idx;
                    ack_d = NREQ'(1) << win_idx;
                    if (sel_dst >= sel_beg) begin
                        state_d      = S_LAUNCH;
                        dma_enable_d = 1'b1;
                        dma_rw_d     = req_rw_i[win_idx];
                        beg_d        = sel_beg;
                        dst_d        = sel_dst;
                    end else begin
                        state_d      = S_REJECT;
                        err_sticky_d = 1'b1;
                    end
                end
            end
            S_LAUNCH: begin
                ptr_d   = ptr_next;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                wdog_d = wdog_q + 1'b1;
                if (dma_finish_i) begin
                    state_d = S_DONE;
                    done_d  = NREQ'(1) << gnt_q;
                end else if (wdog_q == TW'(TIMEOUT-1)) begin
                    state_d      = S_DONE;
                    done_d       = NREQ'(1) << gnt_q;
                    done_err_d   = 1'b1;
                    err_sticky_d = 1'b1;
                end
            end
            S_REJECT: begin
                ptr_d      = ptr_next;
                state_d    = S_DONE;
                done_d     = NREQ'(1) << gnt_q;
                done_err_d = 1'b1;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_h) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            ptr_q        <= '0;
            gnt_q        <= '0;
            wdog_q       <= '0;
            ack_q        <= '0;
            done_q       <= '0;
            done_err_q   <= 1'b0;
            err_sticky_q <= 1'b0;
            dma_enable_q <= 1'b0;
            dma_rw_q     <= 1'b0;
            beg_q        <= '0;
            dst_q        <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            gnt_q        <= gnt_d;
            wdog_q       <= wdog_d;
            ack_q        <= ack_d;
            done_q       <= done_d;
            done_err_q   <= done_err_d;
            err_sticky_q <= err_sticky_d;
            dma_enable_q <= dma_enable_d;
            dma_rw_q     <= dma_rw_d;
            beg_q        <= beg_d;
            dst_q        <= dst_d;
            busy_q       <= busy_d;
        end
    end

    assign ack_o           = ack_q;
    assign done_o          = done_q;
    assign done_err_o      = done_err_q;
    assign err_sticky_o    = err_sticky_q;
    assign dma_enable_o    = dma_enable_q;
    assign dma_rw_o        = dma_rw_q;
    assign dma_sdram_beg_o = beg_q;
    assign dma_sdram_dst_o = dst_q;
    assign busy_o          = busy_q;

endmodule

// File: tb/tb_dma_req_sched.sv
// Bench for dma_req_sched: directed scenarios plus randomized transactions, checked against
// a transaction-level model of grant order, latency, error flags and held descriptors.
module tb_dma_req_sched;

    localparam int NREQ    = 3;
    localparam int AW      = 8;
    localparam int TIMEOUT = 16;
    localparam int TW      = 5;

    logic               clk_h = 1'b0;
    logic               rst_n;
    logic [NREQ-1:0]    req_i;
    logic [NREQ-1:0]    req_rw_i;
    logic [NREQ*AW-1:0] req_beg_i;
    logic [NREQ*AW-1:0] req_dst_i;
    logic [NREQ-1:0]    ack_o;
    logic [NREQ-1:0]    done_o;
    logic               done_err_o;
    logic               err_sticky_o;
    logic               err_clr_i;
    logic               dma_enable_o;
    logic               dma_rw_o;
    logic [AW-1:0]      dma_sdram_beg_o;
    logic [AW-1:0]      dma_sdram_dst_o;
    logic               dma_finish_i;
    logic               busy_o;

    dma_req_sched #(.NREQ(NREQ), .AW(AW), .TIMEOUT(TIMEOUT), .TW(TW)) u_dut (
        .clk_h           (clk_h),
        .rst_n           (rst_n),
        .req_i           (req_i),
        .req_rw_i        (req_rw_i),
        .req_beg_i       (req_beg_i),
        .req_dst_i       (req_dst_i),
        .ack_o           (ack_o),
        .done_o          (done_o),
        .done_err_o      (done_err_o),
        .err_sticky_o    (err_sticky_o),
        .err_clr_i       (err_clr_i),
        .dma_enable_o    (dma_enable_o),
        .dma_rw_o        (dma_rw_o),
        .dma_sdram_beg_o (dma_sdram_beg_o),
        .dma_sdram_dst_o (dma_sdram_dst_o),
        .dma_finish_i    (dma_finish_i),
        .busy_o          (busy_o)
    );

    always #5 clk_h = ~clk_h;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: requester descriptors, pending set, pointer, sticky error, last launch.
    int              beg_m [NREQ];
    int              dst_m [NREQ];
    int              rw_m  [NREQ];
    logic [NREQ-1:0] pending;
    int              ptr_m;
    logic            err_m;
    int              last_rw, last_beg, last_dst;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] all_outputs();
        return {5'd0, ack_o, done_o, done_err_o, err_sticky_o, dma_enable_o, dma_rw_o,
                dma_sdram_beg_o, dma_sdram_dst_o, busy_o};
    endfunction

    task automatic drive_desc();
        for (int i = 0; i < NREQ; i++) begin
            req_rw_i[i]           = rw_m[i][0];
            req_beg_i[i*AW +: AW] = beg_m[i][AW-1:0];
            req_dst_i[i*AW +: AW] = dst_m[i][AW-1:0];
        end
    endtask

    task automatic rand_desc(input int i);
        int r;
        rw_m[i]  = int'($urandom % 2);
        beg_m[i] = int'($urandom % 256);
        r        = int'($urandom % 8);
        if (r < 2)       dst_m[i] = int'($urandom % 256);
        else if (r == 2) dst_m[i] = beg_m[i];
        else             dst_m[i] = beg_m[i] + int'($urandom % (256 - beg_m[i]));
    endtask

    task automatic model_reset();
        pending  = '0;
        ptr_m    = 0;
        err_m    = 1'b0;
        last_rw  = 0;
        last_beg = 0;
        last_dst = 0;
    endtask

    // One transaction, entered and left #1 after the edge that starts an IDLE cycle.
    // fin_j: WAIT cycle (1-based) in which dma_finish is high; 0 means never (watchdog abort).
    task automatic txn(input logic [NREQ-1:0] add, input int fin_j, input bit spur, input bit clr);
        int   g;
        int   kd;
        bit   reject;
        bit   err_flag;
        pending      = pending | add;
        req_i        = pending;
        drive_desc();
        err_clr_i    = clr;
        dma_finish_i = spur;
        check("idle_busy", {31'd0, busy_o}, 32'd0);

        g = -1;
        for (int i = 0; i < NREQ; i++)
            if (g < 0 && pending[(ptr_m + i) % NREQ]) g = (ptr_m + i) % NREQ;
        reject = dst_m[g] < beg_m[g];
        err_m  = reject ? 1'b1 : (clr ? 1'b0 : err_m);
        if (!reject) begin
            last_rw  = rw_m[g];
            last_beg = beg_m[g];
            last_dst = dst_m[g];
        end

        @(posedge clk_h); #1;
        err_clr_i    = 1'b0;
        dma_finish_i = spur;
        check("ack_onehot", {29'd0, ack_o}, 32'd1 << g);
        check("ack_enable", {31'd0, dma_enable_o}, {31'd0, !reject});
        check("ack_desc", {15'd0, dma_rw_o, dma_sdram_beg_o, dma_sdram_dst_o},
              {15'd0, last_rw[0], last_beg[7:0], last_dst[7:0]});
        check("ack_err_sticky", {31'd0, err_sticky_o}, {31'd0, err_m});
        check("ack_no_done", {28'd0, done_o, done_err_o}, 32'd0);
        pending[g] = 1'b0;
        req_i      = pending;
        ptr_m      = (g + 1) % NREQ;

        err_flag = reject || (fin_j == 0);
        kd       = reject ? 1 : ((fin_j == 0) ? TIMEOUT + 1 : fin_j + 1);
        for (int k = 1; k <= kd; k++) begin
            @(posedge clk_h); #1;
            dma_finish_i = !reject && (k == fin_j);
            if (k < kd) begin
                check("wait_quiet", {26'd0, done_o, done_err_o, dma_enable_o, ack_o == 0},
                      32'd1);
                check("wait_busy", {31'd0, busy_o}, 32'd1);
            end else begin
                if (err_flag) err_m = 1'b1;
                check("done_onehot", {29'd0, done_o}, 32'd1 << g);
                check("done_err", {31'd0, done_err_o}, {31'd0, err_flag});
                check("done_err_sticky", {31'd0, err_sticky_o}, {31'd0, err_m});
                check("done_desc_hold", {14'd0, dma_enable_o, dma_rw_o, dma_sdram_beg_o,
                      dma_sdram_dst_o}, {14'd0, 1'b0, last_rw[0], last_beg[7:0], last_dst[7:0]});
            end
        end

        @(posedge clk_h); #1;
        dma_finish_i = 1'b0;
        check("after_done_quiet", {28'd0, done_o, done_err_o}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [NREQ-1:0] add;
        rst_n        = 1'b0;
        req_i        = '0;
        req_rw_i     = '0;
        req_beg_i    = '0;
        req_dst_i    = '0;
        err_clr_i    = 1'b0;
        dma_finish_i = 1'b0;
        model_reset();
        for (int i = 0; i < NREQ; i++) begin
            rw_m[i]  = i % 2;
            beg_m[i] = 16 * i;
            dst_m[i] = 16 * i + 5;
        end
        beg_m[1] = 8'h20;
        dst_m[1] = 8'h20;

        repeat (2) @(posedge clk_h);
        #1;
        check("reset_outputs", all_outputs(), 32'd0);
        rst_n = 1'b1;

        // Round-robin with all three held, then re-request of 0.
        txn(3'b111, 3, 1'b0, 1'b0);
        txn(3'b000, 1, 1'b0, 1'b0);
        txn(3'b000, 2, 1'b0, 1'b0);
        txn(3'b001, 4, 1'b0, 1'b0);

        rw_m[0] = 0; beg_m[0] = 8'h10; dst_m[0] = 8'h1F;
        txn(3'b001, 12, 1'b0, 1'b0);

        rw_m[2] = 1; beg_m[2] = 8'h40; dst_m[2] = 8'h3F;
        txn(3'b100, 1, 1'b0, 1'b0);
        txn(3'b010, 5, 1'b0, 1'b1);

        // Watchdog abort, then clear; finish on the final WAIT cycle still counts as success.
        txn(3'b001, 0, 1'b0, 1'b0);
        txn(3'b010, 2, 1'b0, 1'b1);
        txn(3'b100, TIMEOUT, 1'b0, 1'b0);

        txn(3'b001, 7, 1'b1, 1'b0);
        txn(3'b010, 1, 1'b1, 1'b0);

        // Reset in the middle of WAIT.
        beg_m[0] = 5; dst_m[0] = 9;
        drive_desc();
        req_i = 3'b001;
        @(posedge clk_h); #1;
        req_i = '0;
        repeat (2) @(posedge clk_h);
        #1;
        rst_n = 1'b0;
        @(posedge clk_h); #1;
        check("midwait_reset", all_outputs(), 32'd0);
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < NREQ; i++) rand_desc(i);
        dst_m[0] = beg_m[0];
        txn(3'b111, 3, 1'b0, 1'b0);

        for (int t = 0; t < 60; t++) begin
            add = NREQ'($urandom) & ~pending;
            if ((pending | add) == '0) add[$urandom % NREQ] = 1'b1;
            for (int i = 0; i < NREQ; i++) if (add[i]) rand_desc(i);
            txn(add,
                ($urandom % 10 == 0) ? 0 : int'($urandom_range(1, TIMEOUT)),
                bit'($urandom % 4 == 0),
                bit'($urandom % 3 == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
